// File: rtl/sobol_gen.sv
// Multi-dimension Sobol sequence generator with runtime-loadable direction vectors.
// Optional random digital shift per dimension when SOBOL_SCRAMBLE_EN is defined.
module sobol_gen #(
  parameter int WIDTH    = 16,
  parameter int DIM      = 2,
  parameter int LOGWIDTH = $clog2(WIDTH),
  parameter int LOGDIM   = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  restart,
  input  logic                  dv_we,
  input  logic [LOGDIM-1:0]     dv_dim,
  input  logic [LOGWIDTH-1:0]   dv_idx,
  input  logic [WIDTH-1:0]      dv_data,
`ifdef SOBOL_SCRAMBLE_EN
  input  logic                  scr_we,
`endif
  output logic [DIM*WIDTH-1:0]  seq_o,
  output logic                  wrap_o
);

  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    seq [DIM];
  logic [WIDTH-1:0]    dv  [DIM][WIDTH];
  logic [LOGWIDTH-1:0] c;
  logic                all_ones;
  logic                dim_ok;
  logic                dv_hit;

  // Dim 0 is van der Corput; higher dims start from the Pascal-triangle vectors.
  function automatic logic [WIDTH-1:0] dv_default(input int d, input int k);
    logic [WIDTH-1:0] v;
    v = '0;
    if (d == 0) begin
      v[WIDTH-1-k] = 1'b1;
    end else begin
      v[WIDTH-1] = 1'b1;
      for (int i = 1; i <= k; i++) v = v ^ (v >> 1);
    end
    return v;
  endfunction

  always_comb begin
    c = '0;
    for (int k = WIDTH-1; k >= 0; k--)
      if (!cnt[k]) c = LOGWIDTH'(k);
  end

  assign all_ones = &cnt;
  assign dim_ok   = int'(dv_dim) < DIM;
  assign dv_hit   = dv_we && dim_ok && (int'(dv_idx) < WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wrap_o <= 1'b0;
      for (int d = 0; d < DIM; d++) begin
        seq[d] <= '0;
        for (int k = 0; k < WIDTH; k++) dv[d][k] <= dv_default(d, k);
      end
    end else begin
      wrap_o <= enable && !restart && all_ones;
      if (restart || (enable && all_ones)) begin
        cnt <= '0;
        for (int d = 0; d < DIM; d++) seq[d] <= '0;
      end else if (enable) begin
        cnt <= cnt + 1'b1;
        for (int d = 0; d < DIM; d++) seq[d] <= seq[d] ^ dv[d][c];
      end
      // The step above reads the pre-write vector, so a same-cycle write takes effect next point.
      if (dv_hit) dv[dv_dim][dv_idx] <= dv_data;
    end
  end

`ifdef SOBOL_SCRAMBLE_EN
  logic [WIDTH-1:0] shift [DIM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DIM; d++) shift[d] <= '0;
    end else if (scr_we && dim_ok) begin
      shift[dv_dim] <= dv_data;
    end
  end

  always_comb begin
    seq_o = '0;
    for (int d = 0; d < DIM; d++) seq_o[d*WIDTH +: WIDTH] = seq[d] ^ shift[d];
  end
`else
  always_comb begin
    seq_o = '0;
    for (int d = 0; d < DIM; d++) seq_o[d*WIDTH +: WIDTH] = seq[d];
  end
`endif

endmodule

// File: doc/sobol_gen.md
# sobol_gen

Parametrised multi-dimension Sobol low-discrepancy sequence generator for the unary-rate compute units. It produces DIM independent WIDTH-bit sequences that advance in lock-step, one point per enabled cycle. Direction vectors are runtime-loadable and the sequence period can be restarted. It replaces the fixed 16-bit, single-dimension generator as the random-number source feeding uMUL/uADD comparators.

## Interface
- WIDTH, 16: sequence/direction-vector width; period is 2^WIDTH points.
- DIM, 2: number of dimensions (output channels), 1..16.
- LOGWIDTH, $clog2(WIDTH): direction-vector index width.
- LOGDIM, (DIM>1 ? $clog2(DIM) : 1): dimension select width.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  advance all dimensions by one point.
- restart  in  1  synchronous return to point 0.
- dv_we  in  1  direction-vector write strobe.
- dv_dim  in  LOGDIM  target dimension for dv_we (and scr_we).
- dv_idx  in  LOGWIDTH  target direction-vector index.
- dv_data  in  WIDTH  write data.
- seq_o  out  DIM*WIDTH  current point; dimension d at [d*WIDTH +: WIDTH].
- wrap_o  out  1  one-cycle pulse: period completed.

## Operation
- State: cnt (WIDTH-bit point counter), seq[d] (WIDTH bits per dim), dv[d][k] (DIM x WIDTH x WIDTH).
- c = index of least-significant zero bit of cnt (priority encode of ~cnt, LSB first).
- enable=1, cnt != all-ones: cnt <= cnt+1; seq[d] <= seq[d] ^ dv[d][c] for every d.
- enable=1, cnt == all-ones (no zero bit): cnt <= 0; seq[d] <= 0 for every d; wrap_o pulses next cycle. Gives exact period 2^WIDTH.
- enable=0: cnt, seq hold.
- restart=1: cnt <= 0, seq <= 0, wrap_o not asserted; overrides enable in same cycle. dv untouched.
- dv_we=1: dv[dv_dim][dv_idx] <= dv_data. dv_dim >= DIM or dv_idx >= WIDTH: write ignored.
- Write and enable same cycle hitting the entry selected by c: XOR uses the old value; new value visible from next cycle.
- Reset values of dv: dim 0 identity, dv[0][k] = 1 << (WIDTH-1-k) (van der Corput). Dims >= 1 Pascal recurrence: dv[d][0] = 1 << (WIDTH-1); dv[d][k] = dv[d][k-1] ^ (dv[d][k-1] >> 1).
- No illegal states; any cnt value is valid.

## Timing
- Reset: cnt=0, all seq=0, seq_o=0, wrap_o=0, dv at defaults above (scramble regs 0).
- seq_o is registered state (XOR with scramble reg if compiled in); updates 1 cycle after the enable edge.
- wrap_o: registered, high exactly the one cycle after the wrapping enable.
- rst_n asserted mid-sequence: immediate return to reset values, including dv (loaded vectors lost).

## Configuration
- SOBOL_SCRAMBLE_EN defined: adds input scr_we (1 bit) and DIM WIDTH-bit scramble regs shift[d], reset 0; scr_we=1 writes shift[dv_dim] <= dv_data (dv_we and scr_we both high: both writes occur). seq_o[d] = seq[d] ^ shift[d] (random digital shift); cnt/seq/wrap behaviour unchanged.
- Not defined: no scr_we port, no scramble regs; seq_o[d] = seq[d].

## Test plan
- Reset, WIDTH=16: seq_o=0, wrap_o=0; enable held 4 cycles -> dim0 0x8000, 0xC000, 0x4000, 0x6000; dim1 0x8000, 0x4000, 0xC000, 0x6000.
- WIDTH=4, DIM=2: 16 consecutive enables -> after 16th seq_o=0, cnt=0, wrap_o=1 for one cycle; 17th enable -> dim0 0x8.
- enable toggled 1,0,0,1 -> value held during low cycles; sequence resumes as if gaps absent (dim0 0x8000 then 0xC000).
- 3 enables then restart with enable=1 -> seq_o=0, no wrap_o; next enable gives 0x8000.
- dv_we dim1 idx0 data 0x0001 while enable=1 at cnt=0 -> that step uses 0x8000; after restart, next enable gives dim1=0x0001; write with dv_dim=DIM ignored.
- SOBOL_SCRAMBLE_EN: scr_we dim0 data 0xFFFF -> seq_o dim0 0xFFFF at point 0, 0x7FFF after one enable; dim1 unaffected.
